// File: rtl/fracn_pkg.sv
// Shared definitions for the fractional-N MASH divider: order encodings,
// FSM states, dither LFSR taps and the signed width of the modulator output.
package fracn_pkg;

    typedef enum logic [1:0] {
        ORD_INT  = 2'd0,
        ORD_M1   = 2'd1,
        ORD_M11  = 2'd2,
        ORD_M111 = 2'd3
    } order_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_DIV_DEFAULT = 4;
    localparam int Y_WIDTH         = 4;

    // Fibonacci feedback mask for x^23 + x^18 + 1 (bits 22 and 17)
    localparam logic [31:0] LFSR_TAPS = 32'h0042_0000;

    typedef logic signed [Y_WIDTH-1:0] y_t;

    function automatic y_t bit_to_y(input logic b);
        return {{(Y_WIDTH-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/fracn_div_mash_if.sv
// Configuration/handshake and divided-clock outputs of the fractional-N divider.
interface fracn_div_mash_if #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 24
);
    logic [INT_WIDTH-1:0]  Integer;
    logic [FRAC_WIDTH-1:0] Fraction;
    logic [1:0]            order;
    logic                  dither_en;
    logic                  load;
    logic                  load_ack;
    logic                  Fout;
    logic                  cycle_end;
    logic [INT_WIDTH+1:0]  div_value;

    modport master (
        output Integer, Fraction, order, dither_en, load,
        input  load_ack, Fout, cycle_end, div_value
    );

    modport slave (
        input  Integer, Fraction, order, dither_en, load,
        output load_ack, Fout, cycle_end, div_value
    );
endinterface

// File: rtl/fracn_mash111.sv
// MASH 1 / 1-1 / 1-1-1 modulator. clr together with step restarts the
// accumulators from zero and performs the first step in the same cycle.
module fracn_mash111
    import fracn_pkg::*;
#(
    parameter int FRAC_WIDTH = 24,
    parameter int LFSR_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step,
    input  logic                  clr,
    input  logic [FRAC_WIDTH-1:0] frac,
    input  logic [1:0]            order,
    input  logic                  dither_en,
    output y_t                    y
);
    logic [FRAC_WIDTH-1:0] acc1, acc2, acc3;
    logic [FRAC_WIDTH-1:0] base1, base2, base3;
    logic [FRAC_WIDTH:0]   sum1, sum2, sum3;
    logic                  c2_d, c3_d, c3_dd;
    logic                  tap2, tap3, tap33;
    logic                  c1, c2, c3, dith, advance;
    logic [LFSR_WIDTH-1:0] lfsr;

    always_comb begin
        base1   = clr ? '0 : acc1;
        base2   = clr ? '0 : acc2;
        base3   = clr ? '0 : acc3;
        tap2    = clr ? 1'b0 : c2_d;
        tap3    = clr ? 1'b0 : c3_d;
        tap33   = clr ? 1'b0 : c3_dd;
        dith    = dither_en & lfsr[0];
        sum1    = {1'b0, base1} + {1'b0, frac} + {{FRAC_WIDTH{1'b0}}, dith};
        sum2    = {1'b0, base2} + {1'b0, sum1[FRAC_WIDTH-1:0]};
        sum3    = {1'b0, base3} + {1'b0, sum2[FRAC_WIDTH-1:0]};
        c1      = sum1[FRAC_WIDTH];
        c2      = sum2[FRAC_WIDTH];
        c3      = sum3[FRAC_WIDTH];
        advance = step && (order != ORD_INT);
        y       = '0;
        case (order)
            ORD_M1:   y = bit_to_y(c1);
            ORD_M11:  y = bit_to_y(c1) + bit_to_y(c2) - bit_to_y(tap2);
            ORD_M111: y = bit_to_y(c1) + bit_to_y(c2) - bit_to_y(tap2)
                        + bit_to_y(c3) - bit_to_y(tap3) - bit_to_y(tap3)
                        + bit_to_y(tap33);
            default:  y = '0;
        endcase
    end

    // Integer-only order freezes the accumulators unless a restart clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1  <= '0;
            acc2  <= '0;
            acc3  <= '0;
            c2_d  <= 1'b0;
            c3_d  <= 1'b0;
            c3_dd <= 1'b0;
            lfsr  <= '1;
        end else begin
            if (advance) begin
                acc1  <= sum1[FRAC_WIDTH-1:0];
                acc2  <= sum2[FRAC_WIDTH-1:0];
                acc3  <= sum3[FRAC_WIDTH-1:0];
                c2_d  <= c2;
                c3_d  <= c3;
                c3_dd <= tap3;
            end else if (clr) begin
                acc1  <= '0;
                acc2  <= '0;
                acc3  <= '0;
                c2_d  <= 1'b0;
                c3_d  <= 1'b0;
                c3_dd <= 1'b0;
            end
            if (step) begin
                lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS[LFSR_WIDTH-1:0])};
            end
        end
    end

endmodule

// File: rtl/fracn_div_mash.sv
// Fractional-N clock divider: double-buffered configuration, period counter,
// modulus clamp and registered 50%-ish duty output around a MASH modulator.
module fracn_div_mash
    import fracn_pkg::*;
#(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 24,
    parameter int LFSR_WIDTH = 23,
    parameter int MIN_DIV    = MIN_DIV_DEFAULT
) (
    input logic             Fin,
    input logic             rst_n,
    fracn_div_mash_if.slave bus
);
    localparam int DW = INT_WIDTH + 2;
    localparam logic signed [DW-1:0] MIN_N = DW'(MIN_DIV);

    state_t                state;
    logic [INT_WIDTH-1:0]  int_r, cap_int, nxt_int, eff_int;
    logic [FRAC_WIDTH-1:0] frac_r, cap_frac, nxt_frac, eff_frac;
    logic [1:0]            ord_r, cap_ord, nxt_ord, eff_ord;
    logic                  dith_r, cap_dith, nxt_dith, eff_dith;
    logic                  pending;
    logic [DW-1:0]         count, div_r, n_next;
    logic                  fout_r, cycle_end_r;
    logic                  start, boundary, apply, step;
    logic signed [DW-1:0]  n_sum;
    y_t                    y;

    // A load coinciding with the boundary bypasses the capture registers.
    always_comb begin
        start    = (state == IDLE) && bus.load;
        boundary = (state == RUN) && cycle_end_r;
        apply    = start || (boundary && (pending || bus.load));
        step     = start || boundary;
        nxt_int  = bus.load ? bus.Integer   : cap_int;
        nxt_frac = bus.load ? bus.Fraction  : cap_frac;
        nxt_ord  = bus.load ? bus.order     : cap_ord;
        nxt_dith = bus.load ? bus.dither_en : cap_dith;
        eff_int  = apply ? nxt_int  : int_r;
        eff_frac = apply ? nxt_frac : frac_r;
        eff_ord  = apply ? nxt_ord  : ord_r;
        eff_dith = apply ? nxt_dith : dith_r;
    end

    fracn_mash111 #(
        .FRAC_WIDTH(FRAC_WIDTH),
        .LFSR_WIDTH(LFSR_WIDTH)
    ) u_mash (
        .clk       (Fin),
        .rst_n     (rst_n),
        .step      (step),
        .clr       (apply),
        .frac      (eff_frac),
        .order     (eff_ord),
        .dither_en (eff_dith),
        .y         (y)
    );

    always_comb begin
        n_sum  = $signed({2'b00, eff_int}) + $signed({{(DW-Y_WIDTH){y[Y_WIDTH-1]}}, y});
        n_next = (n_sum < MIN_N) ? MIN_N : n_sum;
    end

    // Fout drops once the remaining count reaches N - (N>>1).
    always_ff @(posedge Fin or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            int_r       <= '0;
            frac_r      <= '0;
            ord_r       <= '0;
            dith_r      <= 1'b0;
            cap_int     <= '0;
            cap_frac    <= '0;
            cap_ord     <= '0;
            cap_dith    <= 1'b0;
            pending     <= 1'b0;
            count       <= '0;
            div_r       <= '0;
            fout_r      <= 1'b0;
            cycle_end_r <= 1'b0;
        end else begin
            if (apply) begin
                int_r   <= nxt_int;
                frac_r  <= nxt_frac;
                ord_r   <= nxt_ord;
                dith_r  <= nxt_dith;
                pending <= 1'b0;
            end else if ((state == RUN) && bus.load) begin
                cap_int  <= bus.Integer;
                cap_frac <= bus.Fraction;
                cap_ord  <= bus.order;
                cap_dith <= bus.dither_en;
                pending  <= 1'b1;
            end
            if (step) begin
                count       <= n_next - DW'(1);
                div_r       <= n_next;
                fout_r      <= |n_next[DW-1:1];
                cycle_end_r <= 1'b0;
            end else if (state == RUN) begin
                count       <= count - DW'(1);
                cycle_end_r <= (count == DW'(1));
                fout_r      <= count > (div_r - (div_r >> 1));
            end
            if (start) begin
                state <= RUN;
            end
        end
    end

    assign bus.load_ack  = apply;
    assign bus.Fout      = fout_r;
    assign bus.cycle_end = cycle_end_r;
    assign bus.div_value = div_r;

endmodule

// File: tb/tb_fracn_div_mash.sv
// Directed bench for fracn_div_mash: integer, MASH-1, MASH-1-1-1, clamp,
// mid-period reload, coincident reload and mid-run reset scenarios.
module tb_fracn_div_mash;
    import fracn_pkg::*;

    typedef struct {
        int len;
        int high;
        int div;
        bit ack;
    } rec_t;

    logic Fin = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    rec_t recs[$];
    int   mon_len = 0;
    int   mon_high = 0;
    bit   mon_on = 1'b0;
    int   ack_total = 0;
    bit   idle_activity = 1'b0;

    fracn_div_mash_if #(.INT_WIDTH(8), .FRAC_WIDTH(24)) bus ();

    fracn_div_mash #(
        .INT_WIDTH (8),
        .FRAC_WIDTH(24),
        .LFSR_WIDTH(23),
        .MIN_DIV   (4)
    ) dut (
        .Fin  (Fin),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 Fin = ~Fin;

    // Period recorder: one entry per observed cycle_end, sampled mid-cycle.
    always @(negedge Fin) begin
        if (bus.load_ack === 1'b1) ack_total++;
        if (mon_on) begin
            mon_len++;
            if (bus.Fout === 1'b1) mon_high++;
            if (bus.cycle_end === 1'b1) begin
                recs.push_back('{mon_len, mon_high, int'(bus.div_value), bus.load_ack === 1'b1});
                mon_len  = 0;
                mon_high = 0;
            end
        end else if (rst_n === 1'b1 && (bus.Fout !== 1'b0 || bus.cycle_end !== 1'b0)) begin
            idle_activity = 1'b1;
        end
    end

    task automatic check_output(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic wait_records(input int n, input int budget);
        int b = 0;
        while (recs.size() < n && b < budget) begin
            @(negedge Fin);
            b++;
        end
        check_output("period_records_within_budget", int'(recs.size() >= n), 1);
    endtask

    function automatic rec_t pop_rec();
        rec_t r;
        r = '{-1, -1, -1, 1'b0};
        if (recs.size() > 0) r = recs.pop_front();
        return r;
    endfunction

    task automatic do_reset();
        mon_on = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge Fin);
        rst_n = 1'b1;
        recs.delete();
    endtask

    task automatic apply_start(input int i, input int f, input int o);
        @(posedge Fin);
        #1;
        bus.Integer   = 8'(i);
        bus.Fraction  = 24'(f);
        bus.order     = 2'(o);
        bus.dither_en = 1'b0;
        bus.load      = 1'b1;
        #1 check_output("ack_on_start", int'(bus.load_ack), 1);
        @(posedge Fin);
        #1;
        bus.load = 1'b0;
        recs.delete();
        mon_len  = 0;
        mon_high = 0;
        mon_on   = 1'b1;
    endtask

    task automatic apply_run_load(input int i);
        @(posedge Fin);
        #1;
        bus.Integer = 8'(i);
        bus.load    = 1'b1;
        @(posedge Fin);
        #1;
        bus.load = 1'b0;
    endtask

    initial begin
        rec_t r;
        int   b;
        int   ymin, ymax, sumy, bad, sum_div, sum_len;
        int   exp4[7];

        rst_n         = 1'b0;
        bus.Integer   = '0;
        bus.Fraction  = '0;
        bus.order     = '0;
        bus.dither_en = 1'b0;
        bus.load      = 1'b0;

        #12;
        check_output("reset_fout", int'(bus.Fout), 0);
        check_output("reset_cycle_end", int'(bus.cycle_end), 0);
        check_output("reset_load_ack", int'(bus.load_ack), 0);
        check_output("reset_div_value", int'(bus.div_value), 0);
        @(negedge Fin);
        rst_n = 1'b1;
        repeat (3) @(negedge Fin);
        check_output("idle_fout_low", int'(bus.Fout), 0);

        // Integer-only 132: 66/66 duty, single acknowledge
        ack_total = 0;
        apply_start(132, 0, 0);
        check_output("int_first_div", int'(bus.div_value), 132);
        check_output("int_first_fout", int'(bus.Fout), 1);
        wait_records(3, 3 * 140);
        for (int k = 0; k < 3; k++) begin
            r = pop_rec();
            check_output("int_period_len", r.len, 132);
            check_output("int_period_high", r.high, 66);
            check_output("int_period_div", r.div, 132);
        end
        check_output("int_ack_count", ack_total, 1);

        // Mid-period reloads 77 then 50 (last wins), then a reload on cycle_end
        do_reset();
        apply_start(100, 0, 0);
        repeat (20) @(negedge Fin);
        apply_run_load(77);
        repeat (10) @(negedge Fin);
        apply_run_load(50);
        wait_records(1, 200);
        r = pop_rec();
        check_output("reload_old_len", r.len, 100);
        check_output("reload_old_div", r.div, 100);
        check_output("reload_old_high", r.high, 50);
        check_output("reload_ack_on_end", int'(r.ack), 1);
        b = 0;
        do begin
            @(negedge Fin);
            b++;
        end while (bus.cycle_end !== 1'b1 && b < 200);
        check_output("coincide_cycle_end_seen", int'(bus.cycle_end), 1);
        bus.Integer = 8'd60;
        bus.load    = 1'b1;
        #1 check_output("coincide_ack", int'(bus.load_ack), 1);
        @(posedge Fin);
        #1;
        bus.load = 1'b0;
        check_output("coincide_div", int'(bus.div_value), 60);
        wait_records(2, 200);
        r = pop_rec();
        check_output("reload_new_len", r.len, 50);
        check_output("reload_new_div", r.div, 50);
        check_output("reload_new_high", r.high, 25);
        r = pop_rec();
        check_output("coincide_len", r.len, 60);
        check_output("coincide_high", r.high, 30);
        check_output("coincide_no_ack", int'(r.ack), 0);

        // Asynchronous reset in the middle of a running period
        repeat (7) @(negedge Fin);
        @(posedge Fin);
        #3;
        rst_n  = 1'b0;
        mon_on = 1'b0;
        #1;
        check_output("midrst_fout", int'(bus.Fout), 0);
        check_output("midrst_cycle_end", int'(bus.cycle_end), 0);
        check_output("midrst_load_ack", int'(bus.load_ack), 0);
        check_output("midrst_div_value", int'(bus.div_value), 0);
        idle_activity = 1'b0;
        @(negedge Fin);
        rst_n = 1'b1;
        repeat (20) @(negedge Fin);
        check_output("midrst_stays_idle", int'(idle_activity), 0);
        check_output("midrst_div_held", int'(bus.div_value), 0);

        // MASH-1 with Fraction = 1/2: 132,133 alternating from a cleared state
        apply_start(132, 1 << 23, 1);
        wait_records(100, 100 * 140);
        sum_div = 0;
        sum_len = 0;
        bad     = 0;
        for (int k = 0; k < 100; k++) begin
            r = pop_rec();
            if (k < 4) check_output("m1_div_alternates", r.div, (k % 2 == 0) ? 132 : 133);
            if (k == 1) check_output("m1_odd_high", r.high, 66);
            sum_div += r.div;
            sum_len += r.len;
            if (r.len != r.div) bad++;
        end
        check_output("m1_sum_div_100", sum_div, 13250);
        check_output("m1_sum_len_100", sum_len, 13250);
        check_output("m1_len_matches_div", bad, 0);

        // MASH-1-1-1 near 1/2: bounded y and long-run mean
        do_reset();
        apply_start(8, 24'h7F_FFFF, 3);
        wait_records(2000, 2000 * 14);
        ymin = 100;
        ymax = -100;
        sumy = 0;
        bad  = 0;
        for (int k = 0; k < 2000; k++) begin
            r = pop_rec();
            if (r.div - 8 < ymin) ymin = r.div - 8;
            if (r.div - 8 > ymax) ymax = r.div - 8;
            sumy += r.div - 8;
            if (r.len != r.div) bad++;
        end
        check_output("m111_y_min_ge_m3", int'(ymin >= -3), 1);
        check_output("m111_y_max_le_4", int'(ymax <= 4), 1);
        check_output("m111_sum_y_window", int'(sumy >= 998 && sumy <= 1002), 1);
        check_output("m111_len_matches_div", bad, 0);

        // Clamp at MIN_DIV: unclamped sequence would be 4,6,3,5,4,6,3
        do_reset();
        apply_start(4, 24'h80_0001, 3);
        wait_records(7, 200);
        exp4 = '{4, 6, 4, 5, 4, 6, 4};
        for (int k = 0; k < 7; k++) begin
            r = pop_rec();
            check_output("clamp_div", r.div, exp4[k]);
            check_output("clamp_len", r.len, exp4[k]);
            check_output("clamp_high", r.high, exp4[k] >> 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fracn_div_mash.md
# fracn_div_mash

Programmable fractional-N clock divider, successor to the fixed MASH divider. Divides input clock `Fin` by a per-period modulus N = Integer + y. y is produced by a runtime-selectable MASH 1 / 1-1 / 1-1-1 sigma-delta modulator with optional LSB dither. Long-run average division is Integer + Fraction/2^FRAC_WIDTH. Sits between the reference oscillator clock and the PLL phase detector. Integer, Fraction and order are double-buffered and take effect on a period boundary, so retuning is glitch-free.

## Interface
- `INT_WIDTH`, 8: width of integer divide word.
- `FRAC_WIDTH`, 24: width of fractional word and of each MASH accumulator.
- `LFSR_WIDTH`, 23: dither LFSR length (taps per shared package).
- `MIN_DIV`, 4: floor applied to the computed N.

Ports:
- `Fin`  in  1  divider input clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Integer`  in  INT_WIDTH  integer part of divide ratio (unsigned).
- `Fraction`  in  FRAC_WIDTH  fractional part, weight 2^-FRAC_WIDTH.
- `order`  in  2  0 = integer only, 1 = MASH-1, 2 = MASH-1-1, 3 = MASH-1-1-1.
- `dither_en`  in  1  add LFSR bit to LSB of first accumulator input.
- `load`  in  1  request to capture Integer/Fraction/order/dither_en.
- `load_ack`  out  1  one-cycle pulse when captured values are applied.
- `Fout`  out  1  divided clock, registered.
- `cycle_end`  out  1  one-cycle pulse on the last Fin cycle of each output period.
- `div_value`  out  INT_WIDTH+2  N of the current period, unsigned.

## Operation
- States: IDLE and RUN.
  - IDLE: Fout = 0, counter frozen.
  - IDLE → RUN on `load`: values are captured, accumulators are cleared, and the first period starts on the next cycle.
  - There is no return to IDLE except by reset.
- Reset values: state = IDLE; Fout, load_ack and cycle_end = 0; div_value = 0; all shadows, accumulators, delay taps and the pending flag = 0; LFSR = all-ones.
- Counter: loaded with N-1 at period start and decremented each cycle. cycle_end = 1 when count == 0.
- Duty cycle: Fout = 1 for the first N>>1 cycles of a period and 0 for the remaining N-(N>>1) cycles.
  - N = 132 gives 66 high / 66 low.
  - N = 133 gives 66 high / 67 low.
- MASH step: once per period, on cycle_end.
  - acc1 += frac + dith, then acc2 += acc1_new, then acc3 += acc2_new, all modulo 2^FRAC_WIDTH. Carries are c1, c2, c3.
  - Order 1: y = c1. Range 0 to +1.
  - Order 2: y = c1 + c2 - c2_d. Range -1 to +2.
  - Order 3: y = c1 + c2 - c2_d + c3 - 2·c3_d + c3_dd. Range -3 to +4.
  - Order 0: y = 0; accumulators hold.
- Next modulus: N_next = int_r + y, computed in signed INT_WIDTH+2 arithmetic and clamped to a floor of MIN_DIV.
  - No upper clamp: INT_WIDTH+2 bits holds 2^INT_WIDTH+3.
- Load handling: `load` in RUN sets a pending flag; further loads before the boundary overwrite the captured values (last wins).
  - Pending is applied at the next cycle_end: shadows update, accumulators and delay taps clear, load_ack pulses in that same cycle.
  - If load and cycle_end coincide, the load is applied at that boundary.
- Reset mid-period: asynchronous return to the reset values above; no partial period is completed.

## Timing
- N for period k+1 is registered on the cycle_end cycle of period k. div_value updates on the first cycle of period k+1.
- Fout changes exactly at period start and at the half-point, one Fin edge after the count comparison (registered output).
- The MASH combinational path must complete within one Fin cycle.

## Structure
- Package `fracn_pkg`: order encodings (ORD_INT, ORD_M1, ORD_M11, ORD_M111), MIN_DIV default, LFSR taps, y width (4-bit signed).
- Sub-module `fracn_mash111`: three accumulators, delay taps, order mux and y output.
  - Inputs: `step` strobe, `clr`.
- Top level holds the FSM, shadow and pending registers, counter, clamp and Fout generation.

## Test plan
- Integer = 132, Fraction = 0, order = 0, load at t0 → every period is 132 cycles with 66/66 duty, and load_ack pulses once.
- Integer = 132, Fraction = 2^23, order = 1, dither off → div_value alternates 132, 133, 132, 133 starting with 132. Average over 1000 periods is 132.5 exactly.
- Integer = 132, Fraction = 2^23-1, order = 3 → every y in [-3, +4], and the mean of N over 10000 periods is within 1e-3 of 132.49999994.
- Integer = 4, order = 3, Fraction = 0x800001 → no period is shorter than 4 cycles (clamp observed on div_value).
- load pulsed mid-period with Integer changing 100 → 50 → period in progress completes at 100, load_ack pulses on its cycle_end, and the next period is 50.
- rst_n deasserted mid-RUN → all outputs reset to the values listed above, the block stays in IDLE until the next load, then the first period matches the scenario above with cleared accumulators.
